led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 32, clock cycles per brightness slot (>=2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 4, anti-ghost blanking cycles before each line (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable; low forces display dark.
REQ-006 SHALL have port frame_data  input  64  line L pixels in bits [8L+7:8L]; bit k = pixel k.
REQ-007 SHALL have port frame_valid  input  1  producer offers frame_data.
REQ-008 SHALL have port frame_ready  output  1  shadow buffer free.
REQ-009 SHALL have port brightness  input  3  on-slots per line = brightness+1.
REQ-010 SHALL have port row  output  8  anode data, active-high, row = {d[0],d[1],...,d[7]} of current line byte d.
REQ-011 SHALL have port col  output  8  cathode select, active-low one-cold; line L drives col[7-L]=0.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when line 0 begins.

Function
REQ-013 SHALL hold a 64-bit active buffer (displayed) and a 64-bit shadow buffer plus pending flag.
REQ-014 SHALL drive frame_ready = !pending combinationally from the registered pending flag.
REQ-015 SHALL, on frame_valid && frame_ready, copy frame_data into shadow and set pending next cycle.
REQ-016 SHALL ignore frame_data when frame_valid && !frame_ready; producer holds data until accepted.
REQ-017 SHALL implement FSM states BLANK, SLOT; per line: BLANK for BLANK_CYCLES, then SLOT for 8 slots x SLOT_CYCLES.
REQ-018 SHALL sample brightness into a line register on the cycle BLANK is entered; mid-line changes take effect next line.
REQ-019 SHALL, in BLANK, drive col=8'hFF, row=8'h00.
REQ-020 SHALL, in SLOT with slot index s <= sampled brightness, drive col per line and row per active buffer byte.
REQ-021 SHALL, in SLOT with s > sampled brightness, drive col=8'hFF, row=8'h00.
REQ-022 SHALL advance line 0..7 after last cycle of slot 7, wrapping 7->0.
REQ-023 SHALL, on wrap 7->0 with pending=1, copy shadow to active and clear pending in the same edge; frame_ready rises the following cycle.
REQ-024 SHALL pulse frame_start for exactly the first BLANK cycle of line 0, including first line after reset/enable.
REQ-025 SHALL give line period BLANK_CYCLES+8*SLOT_CYCLES (260 default) and frame period 8x that (2080 default).
REQ-026 SHALL register row and col (one-cycle latency from state to pins).
REQ-027 SHALL, while en=0, hold line=0, state BLANK, counters 0, col=8'hFF, row=0, frame_start=0.
REQ-028 SHALL, while en=0 and pending=1, swap shadow into active on the next cycle.
REQ-029 SHALL, on en 0->1, start at line 0 BLANK with frame_start pulse that cycle.

Reset
REQ-030 SHALL on rst clear active, shadow, pending, line, slot, cycle counters, state=BLANK.
REQ-031 SHALL output after reset: col=8'hFF, row=8'h00, frame_start=0, frame_ready=1.
REQ-032 SHALL abort any line/frame in progress on rst; no partial swap.

Structure
REQ-033 SHALL place state enum, NUM_LINES=8, NUM_SLOTS=8 in package led_scan_pkg.
REQ-034 SHALL implement cycle/slot/line counting in sub-module led_scan_timer emitting line index, slot index, blank flag, wrap strobe.

Verification
REQ-035 SHALL cover: reset, en=1, brightness=7, frame all 8'hFF -> each line col one-cold low 256 cycles after 4 blank cycles, row=8'hFF.
REQ-036 SHALL cover: brightness=0, line 3 byte 8'h01 -> col=8'hEF, row=8'h80 for 32 cycles then dark 224 cycles.
REQ-037 SHALL cover: offer frame mid-frame -> ready drops, active unchanged until line 0, frame_start coincides with new data.
REQ-038 SHALL cover: second frame_valid while pending -> not accepted, ready low until cycle after swap.
REQ-039 SHALL cover: brightness change 7->2 mid-line 5 -> line 5 keeps 8 slots, line 6 shows 3 slots.
REQ-040 SHALL cover: rst asserted mid line 4 with pending=1 -> next cycle outputs dark, ready=1, active cleared.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED matrix scanner: scan FSM states, matrix geometry
// and the anode bit-order helper.
package led_scan_pkg;

    localparam int NUM_LINES = 8;
    localparam int NUM_SLOTS = 8;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SLOT  = 1'b1
    } scan_state_e;

    // Anode pins are wired MSB-first: pixel 0 of a line lands on row[7].
    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Scan sequencer: per line a blanking interval followed by eight brightness slots,
// lines 0..7 in turn. Held at line 0 / BLANK / count 0 while disabled.
module led_scan_timer
    import led_scan_pkg::*;
#(
    parameter int SLOT_CYCLES  = 32,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [2:0] o_line,
    output logic [2:0] o_slot,
    output logic       o_blank,
    output logic       o_line_end,
    output logic       o_wrap,
    output logic       o_frame_first
);

    localparam int MAXC  = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CYC_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CYC_W-1:0] BLANK_LAST = CYC_W'(BLANK_CYCLES - 1);
    localparam logic [CYC_W-1:0] SLOT_LAST  = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [2:0]       SLOT_MAX   = 3'(NUM_SLOTS - 1);
    localparam logic [2:0]       LINE_MAX   = 3'(NUM_LINES - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic [2:0]       r_slot;
    logic [2:0]       w_slot_nxt;
    logic [2:0]       r_line;
    logic [2:0]       w_line_nxt;
    logic             w_line_end;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_state <= ST_BLANK;
            r_cyc   <= '0;
            r_slot  <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_slot  <= w_slot_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc + 1'b1;
        w_slot_nxt  = r_slot;
        w_line_nxt  = r_line;
        w_line_end  = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cyc == BLANK_LAST) begin
                    w_state_nxt = ST_SLOT;
                    w_cyc_nxt   = '0;
                    w_slot_nxt  = '0;
                end
            end
            ST_SLOT: begin
                if (r_cyc == SLOT_LAST) begin
                    w_cyc_nxt = '0;
                    if (r_slot == SLOT_MAX) begin
                        // Last slot of the line: next line, 3-bit index wraps 7 -> 0.
                        w_state_nxt = ST_BLANK;
                        w_slot_nxt  = '0;
                        w_line_nxt  = r_line + 1'b1;
                        w_line_end  = 1'b1;
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cyc_nxt   = '0;
            end
        endcase
    end

    assign o_line        = r_line;
    assign o_slot        = r_slot;
    assign o_blank       = (r_state == ST_BLANK);
    assign o_line_end    = w_line_end && i_en;
    assign o_wrap        = w_line_end && i_en && (r_line == LINE_MAX);
    assign o_frame_first = i_en && (r_state == ST_BLANK) && (r_cyc == '0) && (r_line == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix scanner with double-buffered frames, per-line PWM brightness
// and anti-ghost blanking. Row/col/frame_start are registered at the pins.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int SLOT_CYCLES  = 32,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [2:0]  brightness,
    output logic [7:0]  row,
    output logic [7:0]  col,
    output logic        frame_start
);

    logic [63:0] r_active;
    logic [63:0] r_shadow;
    logic        r_pending;
    logic [2:0]  r_bright;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic        r_frame_start;

    logic [2:0]  w_line;
    logic [2:0]  w_slot;
    logic        w_blank;
    logic        w_line_end;
    logic        w_wrap;
    logic        w_frame_first;
    logic        w_accept;
    logic        w_swap;
    logic        w_lit;
    logic [7:0]  w_line_byte;

    led_scan_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_en          (en),
        .o_line        (w_line),
        .o_slot        (w_slot),
        .o_blank       (w_blank),
        .o_line_end    (w_line_end),
        .o_wrap        (w_wrap),
        .o_frame_first (w_frame_first)
    );

    assign frame_ready = !r_pending;
    assign w_accept    = frame_valid && !r_pending;
    // Swap only at a frame boundary, or immediately while the display is dark.
    assign w_swap      = r_pending && (w_wrap || !en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= frame_data;
            r_pending <= 1'b1;
        end else if (w_swap) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    // Brightness is latched as each line's blanking begins so a line never changes mid-PWM.
    always_ff @(posedge clk) begin
        if (rst || !en || w_line_end) begin
            r_bright <= brightness;
        end
    end

    assign w_line_byte = r_active[{w_line, 3'b000} +: 8];
    assign w_lit       = !w_blank && (w_slot <= r_bright);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_col         <= 8'hFF;
            r_row         <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_first;
            if (w_lit) begin
                r_col <= ~(8'h80 >> w_line);
                r_row <= bit_reverse8(w_line_byte);
            end else begin
                r_col <= 8'hFF;
                r_row <= 8'h00;
            end
        end
    end

    assign row         = r_row;
    assign col         = r_col;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: stimulus queues the expected lit run of
// every displayed line, a negedge monitor measures runs on the pins and compares.
module tb_led_matrix_scan;

    localparam int SLOT  = 32;
    localparam int BLANK = 4;
    localparam int FRAME = 2080;

    localparam logic [63:0] DATA_A = 64'h8040201008040201;  // byte L = 1<<L
    localparam logic [63:0] ROWS_A = 64'h0102040810204080;  // line L row = 8'h80>>L
    localparam logic [63:0] DATA_B = 64'h0303030303030303;
    localparam logic [63:0] ROWS_B = 64'hC0C0C0C0C0C0C0C0;
    localparam logic [63:0] DATA_C = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  brightness;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        frame_start;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .row         (row),
        .col         (col),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [7:0] col;
        logic [7:0] row;
        int         len;
        int         gap;   // -1: preceding dark stretch not checked
        bit         fs;
    } line_rec_t;

    line_rec_t  exp_q[$];
    line_rec_t  cur;
    logic [7:0] cols_exp [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_line(input logic [7:0] c, input logic [7:0] r, input int len,
                             input int gap, input bit fs);
        line_rec_t e;
        e.col = c; e.row = r; e.len = len; e.gap = gap; e.fs = fs;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [63:0] rows, input int len, input int g0, input int g);
        for (int l = 0; l < 8; l++) begin
            push_line(cols_exp[l], rows[8*l +: 8], len, (l == 0) ? g0 : g, (l == 0));
        end
    endtask

    // Monitor: a run is a stretch of identical (col,row) with some cathode selected.
    bit in_run = 0;
    bit fs_seen = 0;
    logic [7:0] run_col, run_row;
    int run_len = 0;
    int ff_cnt = 0;

    always @(negedge clk) begin
        if (in_run) begin
            if (col == run_col && row == run_row) begin
                run_len++;
            end else begin
                in_run = 0;
                check("line_on_cycles", run_len, cur.len);
                ff_cnt = 0;
            end
        end
        if (!in_run) begin
            if (!en) fs_seen = 0;
            if (frame_start) fs_seen = 1;
            if (col != 8'hFF) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_line actual col=%0h row=%0h required=none", col, row);
                    cur.col = col; cur.row = row; cur.len = -1; cur.gap = -1; cur.fs = 0;
                end else begin
                    cur = exp_q.pop_front();
                    check("line_col", col, cur.col);
                    check("line_row", row, cur.row);
                    check("frame_start_before_line", fs_seen, cur.fs);
                    if (cur.gap >= 0) check("dark_before_line", ff_cnt, cur.gap);
                end
                in_run  = 1;
                run_col = col;
                run_row = row;
                run_len = 1;
                fs_seen = 0;
            end else begin
                ff_cnt++;
                if (row != 8'h00) check("row_dark_when_col_off", row, 0);
            end
        end
    end

    task automatic wait_fs(input int limit);
        int n;
        @(negedge clk);
        n = 1;
        while (!frame_start && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) check("frame_start_timeout", 0, 1);
    endtask

    // Load a frame with the display disabled: accept, then immediate swap.
    task automatic load_idle(input logic [63:0] d);
        frame_data  = d;
        frame_valid = 1'b1;
        @(negedge clk);
        check("ready_after_accept", frame_ready, 0);
        frame_valid = 1'b0;
        @(negedge clk);
        check("ready_after_idle_swap", frame_ready, 1);
    endtask

    task automatic stop_at_next_frame();
        wait_fs(FRAME + 20);
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_cnt;
        rst = 1'b1; en = 1'b0; frame_valid = 1'b0; frame_data = '0; brightness = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_col", col, 8'hFF);
        check("reset_row", row, 8'h00);
        check("reset_frame_start", frame_start, 0);
        check("reset_frame_ready", frame_ready, 1);

        // Full brightness, all pixels on.
        brightness = 3'd7;
        load_idle(DATA_C);
        push_frame(64'hFFFFFFFFFFFFFFFF, 256, -1, 4);
        en = 1'b1;
        wait_fs(20);
        stop_at_next_frame();

        // Brightness 0, single pixel 0 of line 3.
        brightness = 3'd0;
        load_idle(64'h0000_0000_0100_0000);
        push_frame(64'h0000_0000_8000_0000, 32, -1, 228);
        en = 1'b1;
        wait_fs(20);
        stop_at_next_frame();

        // Mid-frame offer, second offer rejected while pending, swap at frame wrap.
        brightness = 3'd7;
        load_idle(DATA_A);
        push_frame(ROWS_A, 256, -1, 4);
        push_frame(ROWS_B, 256, 4, 4);
        en = 1'b1;
        wait_fs(20);
        repeat (600) @(negedge clk);
        frame_data  = DATA_B;
        frame_valid = 1'b1;
        @(negedge clk);
        check("ready_drop_mid_frame", frame_ready, 0);
        frame_data = DATA_C;
        repeat (10) @(negedge clk);
        check("ready_low_while_pending", frame_ready, 0);
        frame_valid = 1'b0;
        n = 0;
        rdy_cnt = 0;
        while (!frame_start && n < FRAME + 20) begin
            @(negedge clk);
            n++;
            if (!frame_start && frame_ready) rdy_cnt++;
        end
        check("frame_start_after_swap", frame_start, 1);
        check("ready_high_cycles_before_frame_start", rdy_cnt, 1);
        check("ready_at_frame_start", frame_ready, 1);
        stop_at_next_frame();

        // Brightness 7 -> 2 during line 5 (active frame is B).
        brightness = 3'd7;
        for (int l = 0; l < 8; l++) begin
            push_line(cols_exp[l], 8'hC0, (l < 6) ? 256 : 96,
                      (l == 0) ? -1 : ((l == 7) ? 164 : 4), (l == 0));
        end
        en = 1'b1;
        wait_fs(20);
        repeat (1400) @(negedge clk);
        brightness = 3'd2;
        stop_at_next_frame();

        // Reset during line 4 with a frame pending.
        brightness = 3'd7;
        load_idle(DATA_A);
        for (int l = 0; l < 4; l++) begin
            push_line(cols_exp[l], ROWS_A[8*l +: 8], 256, (l == 0) ? -1 : 4, (l == 0));
        end
        push_line(8'hF7, 8'h08, 50, 4, 1'b0);
        en = 1'b1;
        wait_fs(20);
        repeat (300) @(negedge clk);
        frame_data  = DATA_B;
        frame_valid = 1'b1;
        @(negedge clk);
        check("ready_low_before_reset", frame_ready, 0);
        frame_valid = 1'b0;
        repeat (792) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_line_col", col, 8'hFF);
        check("rst_mid_line_row", row, 8'h00);
        check("rst_mid_line_ready", frame_ready, 1);
        check("rst_mid_line_frame_start", frame_start, 0);
        push_frame(64'h0, 256, -1, 4);
        @(negedge clk);
        rst = 1'b0;
        wait_fs(20);
        stop_at_next_frame();

        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_run", in_run, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
